// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared definitions for the dual-clock FIFO pointer
//               controllers.
//               - Default pointer sizing.
//               - Gray/binary conversion helpers.
//               The helpers operate on a 32-bit container. Callers
//               zero-extend a narrower pointer in and cast the result back.
//               A zero-extended value converts identically at any width
//               up to 32 bits, so the same functions serve every
//               pointer width.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    localparam int FIFO_ADDR_WIDTH = 3;
    localparam int PTR_WIDTH       = FIFO_ADDR_WIDTH + 1;
    localparam int GRAY_MAX_WIDTH  = 32;

    function automatic logic [GRAY_MAX_WIDTH-1:0] bin2gray(
        input logic [GRAY_MAX_WIDTH-1:0] b
    );
        return b ^ (b >> 1);
    endfunction

    function automatic logic [GRAY_MAX_WIDTH-1:0] gray2bin(
        input logic [GRAY_MAX_WIDTH-1:0] g
    );
        logic [GRAY_MAX_WIDTH-1:0] b;
        b[GRAY_MAX_WIDTH-1] = g[GRAY_MAX_WIDTH-1];
        for (int i = GRAY_MAX_WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/fifo_wptr_full_if.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wptr_full_if
// Description : Bus between the producer and the write-side FIFO controller.
//               The bus also carries the memory write port and the Gray
//               pointers exchanged with the read domain.
//   winc         producer -> ctrl   write request
//   rptr         read dom -> ctrl   Gray read pointer (asynchronous)
//   wclken       ctrl -> memory     write enable
//   waddr        ctrl -> memory     binary write address
//   wptr         ctrl -> read dom   Gray write pointer
//   wfull        ctrl -> producer   full flag
//   walmost_full ctrl -> producer   almost-full flag
//   wfill        ctrl -> producer   occupancy
//   woverflow    ctrl -> producer   sticky overflow flag
// Revision    : 1.0 - initial release
// ============================================================================
interface fifo_wptr_full_if #(
    parameter int ADDR_WIDTH = 3
);
    logic                  winc;
    logic [ADDR_WIDTH:0]   rptr;
    logic                  wclken;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [ADDR_WIDTH:0]   wptr;
    logic                  wfull;
    logic                  walmost_full;
    logic [ADDR_WIDTH:0]   wfill;
    logic                  woverflow;

    // Producer / environment side
    modport master (
        output winc, rptr,
        input  wclken, waddr, wptr, wfull, walmost_full, wfill, woverflow
    );

    // Controller side
    modport slave (
        input  winc, rptr,
        output wclken, waddr, wptr, wfull, walmost_full, wfill, woverflow
    );
endinterface : fifo_wptr_full_if
`default_nettype wire

// File: rtl/fifo_sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : fifo_sync_2ff
// Description : Generic WIDTH-bit two-flop synchronizer with synchronous
//               active-high reset.
//               Only Gray-coded (single-bit-change) buses may pass
//               through it as a group.
//   clk  in   destination clock
//   rst  in   synchronous active-high reset
//   d_i  in   asynchronous input bus
//   q_o  out  synchronized bus, two clk edges of latency
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule : fifo_sync_2ff
`default_nettype wire

// File: rtl/fifo_wptr_full.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wptr_full
// Description : Write-side pointer and full-flag controller of the
//               dual-clock FIFO.
//               - Accepts producer writes and drives the memory write port.
//               - Synchronizes the read Gray pointer into wclk.
//               - Reports full, almost-full, fill and overflow status.
//   wclk  in      write-domain clock
//   wrst  in      synchronous active-high reset
//   w_if  slave   winc/rptr in; wclken, waddr, wptr, wfull,
//                 walmost_full, wfill, woverflow out
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_wptr_full
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH   = 3,   // must be >= 2 for the full compare
    parameter int AFULL_THRESH = 6    // 1 .. 2**ADDR_WIDTH
) (
    input  logic             wclk,
    input  logic             wrst,
    fifo_wptr_full_if.slave  w_if
);
    localparam int                PTR_W     = ADDR_WIDTH + 1;
    localparam logic [PTR_W-1:0]  AFULL_LVL = PTR_W'(AFULL_THRESH);

    logic [PTR_W-1:0] wbin_q;
    logic [PTR_W-1:0] wptr_q;
    logic             wfull_q;
    logic             wafull_q;
    logic [PTR_W-1:0] wfill_q;
    logic             wovf_q;

    logic [PTR_W-1:0] rptr_sync;
    logic [PTR_W-1:0] rbin_s;
    logic             wclken;
    logic [PTR_W-1:0] wbin_d;
    logic [PTR_W-1:0] wptr_d;
    logic [PTR_W-1:0] wfill_d;
    logic             wfull_d;
    logic             wafull_d;
    logic             wovf_d;

    fifo_sync_2ff #(
        .WIDTH (PTR_W)
    ) u_rptr_sync (
        .clk (wclk),
        .rst (wrst),
        .d_i (w_if.rptr),
        .q_o (rptr_sync)
    );

    // A request made while full is dropped here, so memory never sees it.
    assign wclken = w_if.winc & ~wfull_q;

    assign wbin_d = wbin_q + {{ADDR_WIDTH{1'b0}}, wclken};
    assign wptr_d = PTR_W'(bin2gray(32'(wbin_d)));
    assign rbin_s = PTR_W'(gray2bin(32'(rptr_sync)));

    // Full when the next write pointer sits one lap ahead of the read
    // pointer. In Gray code that is the read pointer with its two top bits
    // inverted. The status is computed from the next pointer, so a write
    // shows in the flags after its own edge.
    assign wfull_d  = (wptr_d == {~rptr_sync[PTR_W-1:PTR_W-2],
                                   rptr_sync[PTR_W-3:0]});
    assign wfill_d  = wbin_d - rbin_s;
    assign wafull_d = (wfill_d >= AFULL_LVL);
    assign wovf_d   = wovf_q | (w_if.winc & wfull_q);

    always_ff @(posedge wclk) begin
        if (wrst) begin
            wbin_q   <= '0;
            wptr_q   <= '0;
            wfull_q  <= 1'b0;
            wafull_q <= 1'b0;
            wfill_q  <= '0;
            wovf_q   <= 1'b0;
        end else begin
            wbin_q   <= wbin_d;
            wptr_q   <= wptr_d;
            wfull_q  <= wfull_d;
            wafull_q <= wafull_d;
            wfill_q  <= wfill_d;
            wovf_q   <= wovf_d;
        end
    end

    assign w_if.wclken       = wclken;
    assign w_if.waddr        = wbin_q[ADDR_WIDTH-1:0];
    assign w_if.wptr         = wptr_q;
    assign w_if.wfull        = wfull_q;
    assign w_if.walmost_full = wafull_q;
    assign w_if.wfill        = wfill_q;
    assign w_if.woverflow    = wovf_q;
endmodule : fifo_wptr_full
`default_nettype wire
